// File: rtl/regfile_write_buffer_if.sv
// Bus bundle for regfile_write_buffer: enqueue port, fill control,
// register-file write port, occupancy and bypass lookup.
`timescale 1ns/1ps
interface regfile_write_buffer_if #(
  parameter int addr_width = 1,
  parameter int data_width = 1,
  parameter int depth_log2 = 2
);
  logic [addr_width-1:0] ENQ_ADDR;
  logic [data_width-1:0] ENQ_DATA;
  logic                  ENQ_EN;
  logic                  ENQ_RDY;
  logic                  FILL_START;
  logic [data_width-1:0] FILL_DATA;
  logic                  FILL_BUSY;
  logic [addr_width-1:0] WR_ADDR;
  logic [data_width-1:0] WR_DATA;
  logic                  WR_EN;
  logic [depth_log2:0]   COUNT;
  logic [addr_width-1:0] LK_ADDR;
  logic                  LK_HIT;
  logic [data_width-1:0] LK_DATA;

  // Buffer side
  modport slave (
    input  ENQ_ADDR, ENQ_DATA, ENQ_EN, FILL_START, FILL_DATA, LK_ADDR,
    output ENQ_RDY, FILL_BUSY, WR_ADDR, WR_DATA, WR_EN, COUNT, LK_HIT, LK_DATA
  );

  // Requester side
  modport master (
    output ENQ_ADDR, ENQ_DATA, ENQ_EN, FILL_START, FILL_DATA, LK_ADDR,
    input  ENQ_RDY, FILL_BUSY, WR_ADDR, WR_DATA, WR_EN, COUNT, LK_HIT, LK_DATA
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// Register-file write buffer: circular FIFO of {addr,data} write requests
// drained one per cycle into the register file, plus a fill engine that
// writes one captured value to every address lo..hi once the FIFO is empty.
// Optional bypass lookup enabled by defining BSV_REGFILE_WB_BYPASS_EN.
`timescale 1ns/1ps
module regfile_write_buffer #(
  parameter int addr_width = 1,
  parameter int data_width = 1,
  parameter int depth_log2 = 2,
  parameter int lo         = 0,
  parameter int hi         = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  regfile_write_buffer_if.slave   bus
);

  localparam int depth = 1 << depth_log2;
  localparam logic [depth_log2:0]   depth_c = (depth_log2+1)'(depth);
  localparam logic [addr_width-1:0] lo_a    = addr_width'(lo);
  localparam logic [addr_width-1:0] hi_a    = addr_width'(hi);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FILL} state_t;

  state_t                state_q, state_d;
  logic [depth_log2-1:0] head_q, head_d;
  logic [depth_log2-1:0] tail_q, tail_d;
  logic [depth_log2:0]   count_q, count_d;
  logic                  fill_pend_q, fill_pend_d;
  logic [data_width-1:0] fill_data_q, fill_data_d;
  logic [addr_width-1:0] fill_addr_q, fill_addr_d;
  logic [addr_width-1:0] last_addr_q, last_addr_d;
  logic [data_width-1:0] last_data_q, last_data_d;

  // Entry storage; contents are only meaningful between head and tail.
  logic [addr_width-1:0] mem_addr [depth];
  logic [data_width-1:0] mem_data [depth];

  logic                  enq_rdy;
  logic                  do_enq;
  logic                  do_deq;
  logic                  wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic                  lk_hit;
  logic [data_width-1:0] lk_data;

  // Write-port mux: fill counter in FILL, FIFO head while occupied, else hold.
  always_comb begin
    enq_rdy = (count_q != depth_c) && !fill_pend_q && (state_q != ST_FILL);
    do_enq  = bus.ENQ_EN && enq_rdy;
    wr_en   = 1'b0;
    wr_addr = last_addr_q;
    wr_data = last_data_q;
    do_deq  = 1'b0;
    if (state_q == ST_FILL) begin
      wr_en   = 1'b1;
      wr_addr = fill_addr_q;
      wr_data = fill_data_q;
    end else if (count_q != '0) begin
      wr_en   = 1'b1;
      wr_addr = mem_addr[head_q];
      wr_data = mem_data[head_q];
      do_deq  = 1'b1;
    end
  end

  // Pointer/occupancy update and FSM next-state logic.
  always_comb begin
    head_d      = do_deq ? head_q + 1'b1 : head_q;
    tail_d      = do_enq ? tail_q + 1'b1 : tail_q;
    unique case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    state_d     = state_q;
    fill_pend_d = fill_pend_q;
    fill_data_d = fill_data_q;
    fill_addr_d = fill_addr_q;
    last_addr_d = wr_en ? wr_addr : last_addr_q;
    last_data_d = wr_en ? wr_data : last_data_q;
    unique case (state_q)
      ST_FILL: begin
        // Start requests arriving mid-fill are deliberately dropped.
        fill_addr_d = fill_addr_q + 1'b1;
        if (fill_addr_q == hi_a) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (fill_pend_q && (count_q == '0)) begin
          // Launching the pending fill; a coincident start just repeats it.
          state_d     = ST_FILL;
          fill_addr_d = lo_a;
          fill_pend_d = 1'b0;
        end else begin
          if (bus.FILL_START) begin
            fill_pend_d = 1'b1;
            fill_data_d = bus.FILL_DATA;
          end
          state_d = (count_d != '0) ? ST_DRAIN : ST_IDLE;
        end
      end
    endcase
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fill_pend_q <= 1'b0;
      fill_data_q <= '0;
      fill_addr_q <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fill_pend_q <= fill_pend_d;
      fill_data_q <= fill_data_d;
      fill_addr_q <= fill_addr_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Entry storage write at the tail; no reset needed on the data path.
  always_ff @(posedge CLK) begin
    if (do_enq) begin
      mem_addr[tail_q] <= bus.ENQ_ADDR;
      mem_data[tail_q] <= bus.ENQ_DATA;
    end
  end

`ifdef BSV_REGFILE_WB_BYPASS_EN
  // Per-slot match, ordered by age: index 0 is the oldest (head) entry.
  logic [depth-1:0]      lk_match;
  logic [data_width-1:0] lk_slot_data [depth];

  for (genvar gi = 0; gi < depth; gi++) begin : g_lk
    logic [depth_log2-1:0] slot;
    assign slot             = head_q + depth_log2'(gi);
    assign lk_match[gi]     = ((depth_log2+1)'(gi) < count_q) &&
                              (mem_addr[slot] == bus.LK_ADDR);
    assign lk_slot_data[gi] = mem_data[slot];
  end

  // Youngest matching entry wins, so later slots override earlier ones.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int i = 0; i < depth; i++) begin
      if (lk_match[i]) begin
        lk_hit  = 1'b1;
        lk_data = lk_slot_data[i];
      end
    end
  end
`else
  assign lk_hit  = 1'b0;
  assign lk_data = '0;
`endif

  assign bus.ENQ_RDY   = enq_rdy;
  assign bus.FILL_BUSY = fill_pend_q || (state_q == ST_FILL);
  assign bus.WR_EN     = wr_en;
  assign bus.WR_ADDR   = wr_addr;
  assign bus.WR_DATA   = wr_data;
  assign bus.COUNT     = count_q;
  assign bus.LK_HIT    = lk_hit;
  assign bus.LK_DATA   = lk_data;

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Self-checking bench for regfile_write_buffer (depth_log2=2, addr 4b, data 8b,
// fill range 2..5). Expected writes go into a scoreboard queue as stimulus is
// driven; a negedge monitor pops and compares every WR_EN cycle.
`timescale 1ns/1ps
module tb_regfile_write_buffer;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DL = 2;
  localparam int LO = 2;
  localparam int HI = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  regfile_write_buffer_if #(.addr_width(AW), .data_width(DW), .depth_log2(DL)) bus ();

  regfile_write_buffer #(
    .addr_width(AW), .data_width(DW), .depth_log2(DL), .lo(LO), .hi(HI)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [AW+DW-1:0] sb[$];

  // Every register-file write must match the oldest expected write.
  always @(negedge CLK) begin : mon
    logic [AW+DW-1:0] exp_w;
    if (RST_N && bus.WR_EN !== 1'b0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h en=%b, required no write",
                 bus.WR_ADDR, bus.WR_DATA, bus.WR_EN);
      end else begin
        exp_w = sb.pop_front();
        if ({bus.WR_ADDR, bus.WR_DATA} !== exp_w) begin
          n_err++;
          $display("FAIL wr_order: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   bus.WR_ADDR, bus.WR_DATA, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
        end else begin
          $display("write addr=%0h data=%02h", bus.WR_ADDR, bus.WR_DATA);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  // {WR_EN, ENQ_RDY, FILL_BUSY, COUNT, WR_ADDR, WR_DATA}
  function automatic logic [17:0] status();
    return {bus.WR_EN, bus.ENQ_RDY, bus.FILL_BUSY, bus.COUNT, bus.WR_ADDR, bus.WR_DATA};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #2;
    n_vec++;
    if ({status(), bus.LK_HIT, bus.LK_DATA} !== {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_state: got %h, required %h", {status(), bus.LK_HIT, bus.LK_DATA},
               {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    n_vec++;
    if (status() !== {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_release: got %h, required %h", status(), {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0});
    end
  endtask

  task automatic test_single();
    bus.ENQ_ADDR = 4'd3;
    bus.ENQ_DATA = 8'hA5;
    bus.ENQ_EN   = 1'b1;
    n_vec++;
    if (bus.ENQ_RDY !== 1'b1) begin
      n_err++;
      $display("FAIL single_rdy: got %b, required 1", bus.ENQ_RDY);
    end
    sb.push_back({4'd3, 8'hA5});
    tick();
    bus.ENQ_EN = 1'b0;
    n_vec++;
    if (status() !== {1'b1, 1'b1, 1'b0, 3'd1, 4'd3, 8'hA5}) begin
      n_err++;
      $display("FAIL single_wr: got %h, required %h", status(), {1'b1, 1'b1, 1'b0, 3'd1, 4'd3, 8'hA5});
    end
    tick();
    n_vec++;
    if (status() !== {1'b0, 1'b1, 1'b0, 3'd0, 4'd3, 8'hA5}) begin
      n_err++;
      $display("FAIL single_done: got %h, required %h", status(), {1'b0, 1'b1, 1'b0, 3'd0, 4'd3, 8'hA5});
    end
  endtask

  // Five enqueues through a four-entry ring, so the pointers wrap.
  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 5; i++) begin
      a = 4'(i + 1);
      d = 8'(16 + i * 17);
      bus.ENQ_ADDR = a;
      bus.ENQ_DATA = d;
      bus.ENQ_EN   = 1'b1;
      n_vec++;
      if (bus.ENQ_RDY !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_rdy[%0d]: got %b, required 1", i, bus.ENQ_RDY);
      end
      sb.push_back({a, d});
      tick();
      n_vec++;
      if (status() !== {1'b1, 1'b1, 1'b0, 3'd1, a, d}) begin
        n_err++;
        $display("FAIL b2b_wr[%0d]: got %h, required %h", i, status(), {1'b1, 1'b1, 1'b0, 3'd1, a, d});
      end
    end
    bus.ENQ_EN = 1'b0;
    tick();
    n_vec++;
    if (status() !== {1'b0, 1'b1, 1'b0, 3'd0, 4'd5, 8'(16 + 4 * 17)}) begin
      n_err++;
      $display("FAIL b2b_done: got %h, required %h", status(), {1'b0, 1'b1, 1'b0, 3'd0, 4'd5, 8'(16 + 4 * 17)});
    end
  endtask

  // One queued write plus a fill request; enqueues offered while the fill is
  // pending or running must be dropped, as must a second start mid-fill.
  task automatic test_fill();
    logic [17:0] exp_s;
    bus.ENQ_ADDR   = 4'd9;
    bus.ENQ_DATA   = 8'h3C;
    bus.ENQ_EN     = 1'b1;
    bus.FILL_START = 1'b1;
    bus.FILL_DATA  = 8'h00;
    n_vec++;
    if ({bus.ENQ_RDY, bus.FILL_BUSY} !== 2'b10) begin
      n_err++;
      $display("FAIL fill_pre: got rdy/busy=%b, required 10", {bus.ENQ_RDY, bus.FILL_BUSY});
    end
    sb.push_back({4'd9, 8'h3C});
    for (int k = LO; k <= HI; k++) sb.push_back({4'(k), 8'h00});
    tick();
    bus.ENQ_ADDR   = 4'hE;
    bus.ENQ_DATA   = 8'hEE;
    bus.FILL_START = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 1)      exp_s = {1'b1, 1'b0, 1'b1, 3'd1, 4'd9, 8'h3C};
      else if (c == 2) exp_s = {1'b0, 1'b0, 1'b1, 3'd0, 4'd9, 8'h3C};
      else if (c <= 6) exp_s = {1'b1, 1'b0, 1'b1, 3'd0, 4'(LO + c - 3), 8'h00};
      else             exp_s = {1'b0, 1'b1, 1'b0, 3'd0, 4'(HI), 8'h00};
      n_vec++;
      if (status() !== exp_s) begin
        n_err++;
        $display("FAIL fill_cyc%0d: got %h, required %h", c, status(), exp_s);
      end
      bus.FILL_START = (c == 4);
      bus.FILL_DATA  = (c == 4) ? 8'h77 : 8'h00;
      if (c == 6) bus.ENQ_EN = 1'b0;
      tick();
    end
    n_vec++;
    if ({bus.WR_EN, bus.FILL_BUSY, bus.COUNT} !== 5'b0) begin
      n_err++;
      $display("FAIL fill_after: got en/busy/count=%b, required 00000", {bus.WR_EN, bus.FILL_BUSY, bus.COUNT});
    end
  endtask

  task automatic test_bypass();
    logic [8:0] e1, e2, e3;
`ifdef BSV_REGFILE_WB_BYPASS_EN
    e1 = {1'b1, 8'h11};
    e2 = {1'b1, 8'h22};
`else
    e1 = 9'd0;
    e2 = 9'd0;
`endif
    e3 = 9'd0;
    bus.LK_ADDR  = 4'd7;
    bus.ENQ_ADDR = 4'd7;
    bus.ENQ_DATA = 8'h11;
    bus.ENQ_EN   = 1'b1;
    n_vec++;
    if (bus.LK_HIT !== 1'b0) begin
      n_err++;
      $display("FAIL byp_empty: got hit=%b, required 0", bus.LK_HIT);
    end
    sb.push_back({4'd7, 8'h11});
    tick();
    bus.ENQ_DATA = 8'h22;
    n_vec++;
    if ({bus.LK_HIT, bus.LK_DATA} !== e1) begin
      n_err++;
      $display("FAIL byp_first: got %h, required %h", {bus.LK_HIT, bus.LK_DATA}, e1);
    end
    sb.push_back({4'd7, 8'h22});
    tick();
    bus.ENQ_EN = 1'b0;
    n_vec++;
    if ({bus.LK_HIT, bus.LK_DATA} !== e2) begin
      n_err++;
      $display("FAIL byp_young: got %h, required %h", {bus.LK_HIT, bus.LK_DATA}, e2);
    end
    bus.LK_ADDR = 4'd6;
    #1;
    n_vec++;
    if (bus.LK_HIT !== 1'b0) begin
      n_err++;
      $display("FAIL byp_miss: got hit=%b, required 0", bus.LK_HIT);
    end
    bus.LK_ADDR = 4'd7;
    tick();
    n_vec++;
    if ({bus.LK_HIT, bus.LK_DATA} !== e3) begin
      n_err++;
      $display("FAIL byp_drained: got %h, required %h", {bus.LK_HIT, bus.LK_DATA}, e3);
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.FILL_START = 1'b1;
    bus.FILL_DATA  = 8'h5A;
    sb.push_back({4'd2, 8'h5A});
    sb.push_back({4'd3, 8'h5A});
    tick();
    bus.FILL_START = 1'b0;
    n_vec++;
    if ({bus.WR_EN, bus.FILL_BUSY} !== 2'b01) begin
      n_err++;
      $display("FAIL rmf_pend: got en/busy=%b, required 01", {bus.WR_EN, bus.FILL_BUSY});
    end
    tick();
    tick();
    n_vec++;
    if (status() !== {1'b1, 1'b0, 1'b1, 3'd0, 4'd3, 8'h5A}) begin
      n_err++;
      $display("FAIL rmf_at3: got %h, required %h", status(), {1'b1, 1'b0, 1'b1, 3'd0, 4'd3, 8'h5A});
    end
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    n_vec++;
    if ({status(), bus.LK_HIT, bus.LK_DATA} !== {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL rmf_async: got %h, required %h", {status(), bus.LK_HIT, bus.LK_DATA},
               {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0, 1'b0, 8'd0});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (status() !== {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0}) begin
        n_err++;
        $display("FAIL rmf_idle%0d: got %h, required %h", c, status(), {1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 8'd0});
      end
    end
  endtask

  initial begin
    bus.ENQ_ADDR   = '0;
    bus.ENQ_DATA   = '0;
    bus.ENQ_EN     = 1'b0;
    bus.FILL_START = 1'b0;
    bus.FILL_DATA  = '0;
    bus.LK_ADDR    = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_bypass();
    test_reset_mid_fill();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_empty: got %0d pending writes, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
